// File: rtl/grain_ks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grain_ks_ctrl
// Brief    : LFSR + sequencing stage of a 24-bit Grain-style keystream
//            generator; drives the paired NFSR and emits keystream bits.
// Revision : 1.0 - initial release
// ============================================================================
module grain_ks_ctrl #(
    parameter int INIT_ROUNDS = 48
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [23:0] key_seed,
    input  logic [23:0] iv_seed,
    input  logic [23:0] nfsr_x,
    output logic [23:0] nfsr_seed,
    output logic        nfsr_par_load,
    output logic        nfsr_shift_en,
    output logic        lfsr_ser_out,
    output logic        ks_bit,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        busy
);

    // A zero-round build still needs a 1-bit counter to keep the register legal
    localparam int c_CNT_W = (INIT_ROUNDS > 0) ? $clog2(INIT_ROUNDS + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(INIT_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_INIT = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [23:0]          r_lfsr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_shift;
    logic                 w_in_init;
    logic                 w_z;
    logic                 w_fb;
    logic                 w_unused;

    assign w_in_init = (r_state == S_INIT);

    assign w_z = nfsr_x[1] ^ nfsr_x[7] ^ r_lfsr[3]
               ^ (r_lfsr[5]  & nfsr_x[12])
               ^ (r_lfsr[9]  & r_lfsr[15])
               ^ (r_lfsr[20] & nfsr_x[20]);

    // Filter output is folded back into both registers only while mixing
    assign w_fb = r_lfsr[0] ^ r_lfsr[1] ^ r_lfsr[2] ^ r_lfsr[7] ^ (w_in_init & w_z);

    assign nfsr_seed     = key_seed;
    assign nfsr_shift_en = w_shift;
    assign lfsr_ser_out  = (r_state == S_IDLE) ? 1'b0 : (r_lfsr[0] ^ (w_in_init & w_z));
    assign ks_bit        = ks_valid & w_z;
    assign w_unused      = ^nfsr_x;

    always_comb begin
        w_next        = r_state;
        nfsr_par_load = 1'b0;
        w_shift       = 1'b0;
        ks_valid      = 1'b0;
        busy          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                nfsr_par_load = 1'b1;
                busy          = 1'b1;
                w_next        = (INIT_ROUNDS == 0) ? S_RUN : S_INIT;
            end
            S_INIT: begin
                busy = 1'b1;
                if (stop) begin
                    w_next = S_IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                ks_valid = 1'b1;
                if (stop) begin
                    w_next = S_IDLE;
                end else begin
                    w_shift = ks_ready;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD) begin
                // An all-zero LFSR would never leave zero
                r_lfsr <= (iv_seed == 24'h000000) ? 24'h000001 : iv_seed;
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_lfsr <= {w_fb, r_lfsr[23:1]};
                if (w_in_init) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grain_ks_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_grain_ks_ctrl
// Brief    : Directed bench for grain_ks_ctrl with a behavioural NFSR partner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grain_ks_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop, start0, stop0, ks_ready;
    logic [23:0] key, iv, x, x0;
    logic [23:0] seed, seed0;
    logic        par, sh, ser, kb, kv, bsy;
    logic        par0, sh0, ser0, kb0, kv0, bsy0;
    int          total = 0;
    int          bad   = 0;
    logic        exp_ks [64];
    logic        exp_l0 [64];

    always #5 clk = ~clk;

    grain_ks_ctrl #(.INIT_ROUNDS(48)) dut (
        .Clk(clk), .reset(reset), .start(start), .stop(stop),
        .key_seed(key), .iv_seed(iv), .nfsr_x(x), .nfsr_seed(seed),
        .nfsr_par_load(par), .nfsr_shift_en(sh), .lfsr_ser_out(ser),
        .ks_bit(kb), .ks_valid(kv), .ks_ready(ks_ready), .busy(bsy)
    );

    grain_ks_ctrl #(.INIT_ROUNDS(0)) dut0 (
        .Clk(clk), .reset(reset), .start(start0), .stop(stop0),
        .key_seed(key), .iv_seed(iv), .nfsr_x(x0), .nfsr_seed(seed0),
        .nfsr_par_load(par0), .nfsr_shift_en(sh0), .lfsr_ser_out(ser0),
        .ks_bit(kb0), .ks_valid(kv0), .ks_ready(ks_ready), .busy(bsy0)
    );

    function automatic logic nfsr_fb(input logic [23:0] s, input logic so);
        return s[0] ^ s[5] ^ s[14] ^ (s[3] & s[17]) ^ so;
    endfunction

    function automatic logic filt(input logic [23:0] n, input logic [23:0] l);
        return n[1] ^ n[7] ^ l[3] ^ (l[5] & n[12]) ^ (l[9] & l[15]) ^ (l[20] & n[20]);
    endfunction

    // Partner NFSR models, one per controller
    always_ff @(posedge clk) begin
        if (reset)     x <= '0;
        else if (par)  x <= seed;
        else if (sh)   x <= {nfsr_fb(x, ser), x[23:1]};
    end

    always_ff @(posedge clk) begin
        if (reset)     x0 <= '0;
        else if (par0) x0 <= seed0;
        else if (sh0)  x0 <= {nfsr_fb(x0, ser0), x0[23:1]};
    end

    task automatic build_ref(input logic [23:0] k, input logic [23:0] v, input int rounds);
        logic [23:0] l, n;
        logic        z, fl;
        l = (v == 24'h0) ? 24'h000001 : v;
        n = k;
        for (int r = 0; r < rounds; r++) begin
            z  = filt(n, l);
            fl = l[0] ^ l[1] ^ l[2] ^ l[7] ^ z;
            n  = {nfsr_fb(n, l[0] ^ z), n[23:1]};
            l  = {fl, l[23:1]};
        end
        for (int i = 0; i < 64; i++) begin
            exp_ks[i] = filt(n, l);
            exp_l0[i] = l[0];
            fl = l[0] ^ l[1] ^ l[2] ^ l[7];
            n  = {nfsr_fb(n, l[0]), n[23:1]};
            l  = {fl, l[23:1]};
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (kv !== 1'b1 && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check(tag, {31'd0, kv}, 32'd1);
    endtask

    initial begin
        int cyc, first, busy_cnt, sh_cnt, par_cnt, overlap;
        reset = 1'b1; start = 1'b0; stop = 1'b0; start0 = 1'b0; stop0 = 1'b0;
        ks_ready = 1'b0; key = 24'h123456; iv = 24'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_par",   {31'd0, par}, 0);
        check("rst_shift", {31'd0, sh},  0);
        check("rst_valid", {31'd0, kv},  0);
        check("rst_busy",  {31'd0, bsy}, 0);
        check("rst_ser",   {31'd0, ser}, 0);
        check("rst_ksbit", {31'd0, kb},  0);
        check("seed_pass", {8'd0, seed}, 32'h123456);
        reset = 1'b0;
        @(negedge clk);

        // Zero IV guard and session timing
        key = 24'h0; iv = 24'h0; start = 1'b1;
        first = 0; busy_cnt = 0; sh_cnt = 0; par_cnt = 0; overlap = 0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            busy_cnt += int'(bsy);
            sh_cnt   += int'(sh);
            par_cnt  += int'(par);
            overlap  += int'(par & sh);
            if (cyc == 1) begin
                check("load_par",   {31'd0, par}, 1);
                check("load_shift", {31'd0, sh},  0);
            end
            if (cyc == 2) check("guard_ser", {31'd0, ser}, 1);
            if (kv === 1'b1) begin
                first = cyc;
                break;
            end
        end
        check("valid_rise", first,    50);
        check("busy_cnt",   busy_cnt, 49);
        check("shift_cnt",  sh_cnt,   48);
        check("par_cnt",    par_cnt,  1);
        check("overlap",    overlap,  0);

        // start ignored in RUN; stop beats ks_ready
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ign_valid", {31'd0, kv},  1);
        check("start_ign_par",   {31'd0, par}, 0);
        stop = 1'b1; ks_ready = 1'b1;
        #1;
        check("stop_noshift", {31'd0, sh}, 0);
        @(negedge clk);
        stop = 1'b0;
        check("stop_valid", {31'd0, kv},  0);
        check("stop_busy",  {31'd0, bsy}, 0);
        check("stop_ksbit", {31'd0, kb},  0);

        // Keystream with a 10-cycle back-pressure gap
        key = 24'hA5A5A5; iv = 24'h3C3C3C;
        build_ref(key, iv, 48);
        ks_ready = 1'b1; start = 1'b1;
        wait_valid("s3_wait");
        for (int i = 0; i <= 32; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("s3_bit%0d", i), {31'd0, kb}, {31'd0, exp_ks[i]});
        end
        ks_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("hold_bit",   {31'd0, kb},  {31'd0, exp_ks[32]});
            check("hold_shift", {31'd0, sh},  0);
            check("hold_ser",   {31'd0, ser}, {31'd0, exp_l0[32]});
        end
        ks_ready = 1'b1;
        for (int i = 33; i < 64; i++) begin
            @(negedge clk);
            check($sformatf("s4_bit%0d", i), {31'd0, kb}, {31'd0, exp_ks[i]});
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Reset in the middle of init, then a clean rerun
        start = 1'b1; sh_cnt = 0;
        for (int n = 0; n < 100 && sh_cnt < 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            sh_cnt += int'(sh);
        end
        check("mid_rounds", sh_cnt, 20);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_par",   {31'd0, par}, 0);
        check("mrst_shift", {31'd0, sh},  0);
        check("mrst_valid", {31'd0, kv},  0);
        check("mrst_busy",  {31'd0, bsy}, 0);
        check("mrst_ser",   {31'd0, ser}, 0);
        check("mrst_ksbit", {31'd0, kb},  0);
        reset = 1'b0; start = 1'b1;
        wait_valid("s5_wait");
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("s5_bit%0d", i), {31'd0, kb}, {31'd0, exp_ks[i]});
        end

        // Zero-round instance
        build_ref(key, iv, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("r0_par",   {31'd0, par0}, 1);
        check("r0_valid", {31'd0, kv0},  0);
        check("r0_busy",  {31'd0, bsy0}, 1);
        @(negedge clk);
        check("r0_valid2", {31'd0, kv0},  1);
        check("r0_busy2",  {31'd0, bsy0}, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("r0_bit%0d", i), {31'd0, kb0}, {31'd0, exp_ks[i]});
        end
        stop0 = 1'b1;
        #1;
        check("r0_stop_shift", {31'd0, sh0}, 0);
        @(negedge clk);
        stop0 = 1'b0;
        check("r0_stop_valid", {31'd0, kv0}, 0);
        check("r0_stop_ksbit", {31'd0, kb0}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
